// File: rtl/score_disp_pkg.sv
// Shared scan-state encodings and segment patterns
// for the two-digit score display.
package score_disp_pkg;

  typedef enum logic [1:0] {
    SHOW0 = 2'd0,
    GAP0  = 2'd1,
    SHOW1 = 2'd2,
    GAP1  = 2'd3
  } scan_t;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-high 7-segment pattern;
// non-decimal codes render as a dash.
module bcd_to_7seg
  import score_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_7seg_mux.sv
// Two-digit multiplexed score display: frame-latched
// digits, leading-zero blanking, blink burst on change.
module score_7seg_mux
  import score_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 4096,
  parameter int FLASH_FRAMES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] q0,
  input  logic [3:0] q1,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] dig_en
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] F_LOAD = FW'(FLASH_FRAMES);

  scan_t         r_state;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_d0;
  logic [3:0]    r_d1;
  logic [FW-1:0] r_flash;
  logic          r_primed;

  scan_t         w_state_n;
  logic [PW-1:0] w_presc_n;
  logic          w_latch;
  logic          w_chg;
  logic          w_blink;
  logic          w_lz;
  logic [1:0]    w_dig;
  logic [3:0]    w_digit;
  logic [6:0]    w_dec;
  logic [6:0]    w_seg;

  always_comb begin
    w_state_n = r_state;
    w_presc_n = r_presc;
    unique case (r_state)
      SHOW0: begin
        if (r_presc == P_LAST) begin
          w_state_n = GAP0;
          w_presc_n = '0;
        end else begin
          w_presc_n = r_presc + 1'b1;
        end
      end
      GAP0: w_state_n = SHOW1;
      SHOW1: begin
        if (r_presc == P_LAST) begin
          w_state_n = GAP1;
          w_presc_n = '0;
        end else begin
          w_presc_n = r_presc + 1'b1;
        end
      end
      GAP1: w_state_n = SHOW0;
      default: w_state_n = GAP1;
    endcase
  end

  // Score only enters the display on the frame boundary
  assign w_latch = (r_state == GAP1);
  assign w_chg   = ({q1, q0} != {r_d1, r_d0});

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= GAP1;
      r_presc  <= '0;
      r_d0     <= '0;
      r_d1     <= '0;
      r_flash  <= '0;
      r_primed <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_presc <= w_presc_n;
      if (w_latch) begin
        r_d0     <= q0;
        r_d1     <= q1;
        r_primed <= 1'b1;
        if (r_primed && w_chg) begin
          r_flash <= F_LOAD;
        end else if (r_flash != '0) begin
          r_flash <= r_flash - 1'b1;
        end
      end
    end
  end

  // Odd burst counts blank the whole frame
  assign w_blink = r_flash[0];
  assign w_lz    = blank_lz && (r_d1 == 4'd0);

  always_comb begin
    w_dig = 2'b00;
    unique case (r_state)
      SHOW0:   w_dig = {1'b0, !w_blink};
      SHOW1:   w_dig = {!w_blink && !w_lz, 1'b0};
      default: w_dig = 2'b00;
    endcase
  end

  assign w_digit = (r_state == SHOW1) ? r_d1 : r_d0;

  bcd_to_7seg u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

  assign w_seg  = (w_dig != 2'b00) ? w_dec : SEG_OFF;
  assign seg    = SEG_ACTIVE_LOW ? ~w_seg : w_seg;
  assign dig_en = DIG_ACTIVE_LOW ? ~w_dig : w_dig;

endmodule

// File: tb/tb_score_7seg_mux.sv
// Directed bench for score_7seg_mux with a
// 10-cycle frame (REFRESH_DIV=4, FLASH_FRAMES=4).
module tb_score_7seg_mux;

  logic       clk;
  logic       clr;
  logic [3:0] q0;
  logic [3:0] q1;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] dig_en;

  int total;
  int bad;

  score_7seg_mux #(
    .REFRESH_DIV    (4),
    .FLASH_FRAMES   (4),
    .SEG_ACTIVE_LOW (1'b0),
    .DIG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .q0       (q0),
    .q1       (q1),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dig_en   (dig_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [1:0] ed,
    input logic [6:0] es
  );
    total++;
    assert ({dig_en, seg} === {ed, es})
    else begin
      bad++;
      $error("FAIL %s: got dig_en=%b seg=%h, want dig_en=%b seg=%h",
             tag, dig_en, seg, ed, es);
    end
  endtask

  // Walk one frame from its latch edge, checking every cycle
  task automatic do_frame(
    input string      tag,
    input logic [6:0] us,
    input logic [6:0] ts,
    input logic       blk,
    input logic       toff,
    input int         chg_at,
    input logic [3:0] chg_q0,
    input int         ncyc
  );
    logic [1:0] ed;
    logic [6:0] es;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      ed = 2'b00;
      es = 7'h00;
      if (c < 4) begin
        if (!blk) begin
          ed = 2'b01;
          es = us;
        end
      end else if (c >= 5 && c < 9) begin
        if (!blk && !toff) begin
          ed = 2'b10;
          es = ts;
        end
      end
      chk($sformatf("%s.c%0d", tag, c + 1), ed, es);
      if (c == chg_at) q0 = chg_q0;
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    clr      = 1'b1;
    q0       = 4'd0;
    q1       = 4'd0;
    blank_lz = 1'b0;

    @(negedge clk);
    chk("reset", 2'b00, 7'h00);
    clr = 1'b0;

    // Basic scan of 00
    do_frame("f1", 7'h3F, 7'h3F, 1'b0, 1'b0, -1, 4'd0, 10);

    // Leading-zero blanking, then a real tens digit
    q0 = 4'd7;
    blank_lz = 1'b1;
    do_frame("lz", 7'h07, 7'h00, 1'b0, 1'b1, -1, 4'd0, 10);
    q1 = 4'd4;
    do_frame("t4", 7'h07, 7'h66, 1'b0, 1'b0, -1, 4'd0, 10);

    // Mid-frame input change must wait for the next latch
    q0 = 4'd3;
    blank_lz = 1'b0;
    do_frame("midA", 7'h4F, 7'h66, 1'b0, 1'b0, 6, 4'd8, 10);
    do_frame("midB", 7'h7F, 7'h66, 1'b0, 1'b0, -1, 4'd0, 10);

    // Blink burst 05 -> 06
    q1 = 4'd0;
    q0 = 4'd5;
    do_frame("s05", 7'h6D, 7'h3F, 1'b0, 1'b0, -1, 4'd0, 10);
    q0 = 4'd6;
    do_frame("bN0", 7'h7D, 7'h3F, 1'b0, 1'b0, -1, 4'd0, 10);
    do_frame("bN1", 7'h7D, 7'h3F, 1'b1, 1'b0, -1, 4'd0, 10);
    do_frame("bN2", 7'h7D, 7'h3F, 1'b0, 1'b0, -1, 4'd0, 10);
    do_frame("bN3", 7'h7D, 7'h3F, 1'b1, 1'b0, -1, 4'd0, 10);
    do_frame("bN4", 7'h7D, 7'h3F, 1'b0, 1'b0, -1, 4'd0, 10);
    do_frame("bN5", 7'h7D, 7'h3F, 1'b0, 1'b0, -1, 4'd0, 10);

    // Retrigger: change again at burst frame N+2
    q0 = 4'd5;
    do_frame("rN0", 7'h6D, 7'h3F, 1'b0, 1'b0, -1, 4'd0, 10);
    do_frame("rN1", 7'h6D, 7'h3F, 1'b1, 1'b0, -1, 4'd0, 10);
    q0 = 4'd7;
    do_frame("rN2", 7'h07, 7'h3F, 1'b0, 1'b0, -1, 4'd0, 10);
    do_frame("rN3", 7'h07, 7'h3F, 1'b1, 1'b0, -1, 4'd0, 10);
    do_frame("rN4", 7'h07, 7'h3F, 1'b0, 1'b0, -1, 4'd0, 10);
    do_frame("rN5", 7'h07, 7'h3F, 1'b1, 1'b0, -1, 4'd0, 10);
    do_frame("rN6", 7'h07, 7'h3F, 1'b0, 1'b0, -1, 4'd0, 10);

    // Non-decimal codes show dashes
    q0 = 4'hC;
    q1 = 4'hF;
    do_frame("dash", 7'h40, 7'h40, 1'b0, 1'b0, -1, 4'd0, 10);

    // Reset inside a blank burst frame
    do_frame("cb", 7'h40, 7'h40, 1'b1, 1'b0, -1, 4'd0, 3);
    q1 = 4'd1;
    q0 = 4'd2;
    #2 clr = 1'b1;
    #1 chk("clr_blank", 2'b00, 7'h00);
    @(negedge clk);
    chk("clr_hold", 2'b00, 7'h00);
    clr = 1'b0;
    do_frame("pc0", 7'h5B, 7'h06, 1'b0, 1'b0, -1, 4'd0, 10);
    do_frame("pc1", 7'h5B, 7'h06, 1'b0, 1'b0, -1, 4'd0, 10);

    // Reset while a digit is lit takes effect at once
    do_frame("cl", 7'h5B, 7'h06, 1'b0, 1'b0, -1, 4'd0, 2);
    #2 clr = 1'b1;
    #1 chk("clr_lit", 2'b00, 7'h00);
    @(negedge clk);
    clr = 1'b0;
    do_frame("pl0", 7'h5B, 7'h06, 1'b0, 1'b0, -1, 4'd0, 10);
    do_frame("pl1", 7'h5B, 7'h06, 1'b0, 1'b0, -1, 4'd0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_7seg_mux.md
Name: score_7seg_mux

Overview:
- Display stage directly downstream of the PONG two-digit BCD score counter.
- Takes the units digit q0 and the tens digit q1, and drives a 2-digit time-multiplexed 7-segment display.
- Latches the score once per scan frame, so a digit never changes mid-frame (no tearing).
- Supports optional leading-zero blanking and a blink burst whenever the score changes.

Parameters:
- REFRESH_DIV, 4096: clk cycles each digit is lit per scan slot (>=2).
- FLASH_FRAMES, 16: frames in the blink burst after a score change (even, >=2).
- SEG_ACTIVE_LOW, 0: 1 inverts seg outputs.
- DIG_ACTIVE_LOW, 0: 1 inverts dig_en outputs.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset. Asynchronous, active-high.
- q0  in  4  units BCD digit from the score counter.
- q1  in  4  tens BCD digit from the score counter.
- blank_lz  in  1  1 = tens digit dark when the latched tens digit is 0.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dig_en  out  2  digit enables: [0] units, [1] tens.

Behaviour:
- Scan FSM has 4 states:
  - SHOW0: REFRESH_DIV cycles, units digit lit.
  - GAP0: 1 cycle, all digits off.
  - SHOW1: REFRESH_DIV cycles, tens digit lit.
  - GAP1: 1 cycle, all digits off.
  - Sequence is SHOW0->GAP0->SHOW1->GAP1->SHOW0.
  - Prescaler counts 0..REFRESH_DIV-1 within each SHOW state, then wraps to 0 on leaving it.
  - One frame = 2*REFRESH_DIV+2 cycles.
- Latch: only on the GAP1->SHOW0 edge, {q1,q0} is captured into the display registers d1,d0. Inputs have no other path to the outputs.
- Outputs are decoded combinationally from registered state only (Moore).
- Decode, in active-high hex:
  - 0..9 = 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - Values 10..15 show a dash = 40.
- seg shows all-off in GAP states and whenever no digit is enabled.
- Leading zero: if blank_lz=1 and d1==0, dig_en[1] stays inactive during SHOW1 and seg is off. blank_lz is sampled live, not latched.
- Change flash:
  - At the latch edge, a flag `primed` is checked. If primed=1 and the new {q1,q0} differs from {d1,d0}, flash_cnt loads FLASH_FRAMES.
  - Otherwise, if flash_cnt>0, flash_cnt decrements.
  - primed is set at the first latch edge after reset. The first latch after reset never triggers a flash.
  - While flash_cnt[0]==1, both dig_en stay inactive for the whole frame. The scan timing continues unchanged.
  - A new change during a burst reloads FLASH_FRAMES (retrigger).
- Reset (clr=1, asynchronous): state=GAP1, prescaler=0, d0=d1=0, flash_cnt=0, primed=0. dig_en is inactive and seg is all-off, both at the polarity given by the parameters, and both take effect immediately.
- First rising edge after clr deasserts: GAP1->SHOW0, inputs are latched, and the units digit lights that cycle.
- clr asserted mid-frame or mid-burst: the frame is aborted and the burst is cancelled.
- Polarity: inversion is applied last, to seg and dig_en only. Inactive means deasserted at the configured polarity.

Decomposition:
- Shared package score_disp_pkg:
  - scan-state encodings (SHOW0, GAP0, SHOW1, GAP1);
  - the 7-bit segment constants for 0..9 and DASH;
  - SEG_OFF.
- One combinational sub-module: bcd_to_7seg (4-bit in, 7-bit active-high out, dash for values above 9).
- Prescaler, FSM, latch, flash logic and polarity stay in score_7seg_mux.
- Widths: prescaler $clog2(REFRESH_DIV), flash_cnt $clog2(FLASH_FRAMES+1).

Test Plan:
Bench uses REFRESH_DIV=4, FLASH_FRAMES=4, active-high polarity (frame = 10 cycles).
1. clr=1 with q1=0, q0=0, blank_lz=0 -> dig_en=00, seg=00. Release -> cycles 1-4: dig_en=01, seg=3F; cycle 5: 00/00; cycles 6-9: dig_en=10, seg=3F; cycle 10: gap.
2. q1=0, q0=7, blank_lz=1 -> units slots show seg=07. Tens slots show dig_en=00, seg=00. Set q1=4 -> after the next latch, tens slots show seg=66.
3. Change q0 3->8 during SHOW1 of frame N -> frame N tens and units are unchanged. Frame N+1 units shows 7F.
4. Score 05->06 latched at frame N (after primed) -> N shows 7D. N+1 is blank (dig_en=00 all frame), N+2 shown, N+3 blank, N+4 onward normal. A change to 07 at N+2 restarts the sequence.
5. q0=4'hC, q1=4'hF -> both slots seg=40.
6. Assert clr mid-blank-frame of a burst -> outputs off immediately. After release, first frame shows the current score, and the first latch produces no flash even though the score differs from 00.
